// File: rtl/bw_io_impctl_cal_seq.sv
`default_nettype none
// ============================================================================
// Module   : bw_io_impctl_cal_seq
// Brief    : IO impedance-calibration sequencer. Walks the pull-up and then the
//            pull-down drive code from comparator feedback until each dithers
//            around the target, then hands the codes to the pads (valid/ack).
// Options  : IMPCTL_CAL_AVG_EN - majority-of-three comparator sampling.
// Revision : 1.0 - initial release
// ============================================================================
module bw_io_impctl_cal_seq #(
    parameter int CODE_W       = 8,
    parameter int DIV_LOG2     = 3,
    parameter int SETTLE_TICKS = 4,
    parameter int LOCK_CNT     = 3
) (
    input  logic              l2clk,
    input  logic              global_reset,
    input  logic              start,
    input  logic              cal_enable,
    input  logic              comp_hi,
    input  logic              upd_ack,
    output logic [CODE_W-1:0] pu_code,
    output logic [CODE_W-1:0] pd_code,
    output logic              sel_pd,
    output logic              upd_valid,
    output logic              busy,
    output logic              locked,
    output logic              sat_err
);

    localparam int SET_W = (SETTLE_TICKS > 1) ? $clog2(SETTLE_TICKS) : 1;
    localparam int REV_W = $clog2(LOCK_CNT + 1);

    localparam logic [CODE_W-1:0] c_CODE_MID = {1'b1, {(CODE_W-1){1'b0}}};
    localparam logic [CODE_W-1:0] c_CODE_MAX = '1;
    localparam logic [CODE_W-1:0] c_CODE_MIN = '0;
    localparam logic [SET_W-1:0]  c_SET_LAST = SET_W'(SETTLE_TICKS - 1);
    localparam logic [REV_W-1:0]  c_LOCK     = REV_W'(LOCK_CNT);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PU_SETTLE = 3'd1,
        S_PU_SAMPLE = 3'd2,
        S_PD_SETTLE = 3'd3,
        S_PD_SAMPLE = 3'd4,
        S_UPDATE    = 3'd5
    } state_t;

    state_t              r_state,    w_state_nxt;
    logic [DIV_LOG2-1:0] r_div;
    logic [SET_W-1:0]    r_set_cnt,  w_set_cnt_nxt;
    logic [REV_W-1:0]    r_rev,      w_rev_nxt;
    logic                r_prev_dir, w_prev_dir_nxt;
    logic                r_prev_vld, w_prev_vld_nxt;
    logic [CODE_W-1:0]   r_pu_code,  w_pu_code_nxt;
    logic [CODE_W-1:0]   r_pd_code,  w_pd_code_nxt;
    logic                r_sel_pd,   w_sel_pd_nxt;
    logic                r_upd_valid, w_upd_valid_nxt;
    logic                r_locked,   w_locked_nxt;
    logic                r_sat_err,  w_sat_err_nxt;

    logic                w_tick;
    logic                w_eval;
    logic                w_dir;
    logic [CODE_W-1:0]   w_cur_code;
    logic [CODE_W-1:0]   w_stepped;
    logic                w_at_lim;
    logic [REV_W-1:0]    w_rev_upd;
    logic                w_done;

    // Slow sample strobe shared with the impctl divide-by-2^DIV_LOG2 clock.
    always_ff @(posedge l2clk) begin
        if (global_reset) r_div <= '0;
        else              r_div <= r_div + 1'b1;
    end
    assign w_tick = &r_div;

`ifdef IMPCTL_CAL_AVG_EN
    logic       w_in_sample;
    logic [1:0] r_smp_cnt, w_smp_cnt_nxt;
    logic [1:0] r_smp,     w_smp_nxt;

    assign w_in_sample = (r_state == S_PU_SAMPLE) || (r_state == S_PD_SAMPLE);
    assign w_eval      = w_tick && (r_smp_cnt == 2'd2);
    assign w_dir       = (r_smp[0] & r_smp[1]) | (r_smp[0] & comp_hi) | (r_smp[1] & comp_hi);

    always_comb begin
        w_smp_cnt_nxt = r_smp_cnt;
        w_smp_nxt     = r_smp;
        if (!w_in_sample) begin
            w_smp_cnt_nxt = 2'd0;
        end else if (w_tick) begin
            if (r_smp_cnt == 2'd2) begin
                w_smp_cnt_nxt = 2'd0;
            end else begin
                w_smp_nxt[r_smp_cnt[0]] = comp_hi;
                w_smp_cnt_nxt           = r_smp_cnt + 2'd1;
            end
        end
    end

    always_ff @(posedge l2clk) begin
        if (global_reset) begin
            r_smp_cnt <= 2'd0;
            r_smp     <= 2'd0;
        end else begin
            r_smp_cnt <= w_smp_cnt_nxt;
            r_smp     <= w_smp_nxt;
        end
    end
`else
    assign w_eval = w_tick;
    assign w_dir  = comp_hi;
`endif

    assign w_cur_code = (r_state == S_PD_SAMPLE) ? r_pd_code : r_pu_code;
    assign w_stepped  = w_dir ? (w_cur_code + 1'b1) : (w_cur_code - 1'b1);
    assign w_at_lim   = w_dir ? (w_cur_code == c_CODE_MAX) : (w_cur_code == c_CODE_MIN);
    assign w_rev_upd  = r_rev + REV_W'(r_prev_vld && (w_dir != r_prev_dir));

    always_comb begin
        w_state_nxt     = r_state;
        w_set_cnt_nxt   = r_set_cnt;
        w_rev_nxt       = r_rev;
        w_prev_dir_nxt  = r_prev_dir;
        w_prev_vld_nxt  = r_prev_vld;
        w_pu_code_nxt   = r_pu_code;
        w_pd_code_nxt   = r_pd_code;
        w_sel_pd_nxt    = r_sel_pd;
        w_upd_valid_nxt = r_upd_valid;
        w_locked_nxt    = r_locked;
        w_sat_err_nxt   = r_sat_err;
        w_done          = 1'b0;

        // Dropping cal_enable abandons the run in place; no handshake completes.
        if (r_state != S_IDLE && !cal_enable) begin
            w_state_nxt     = S_IDLE;
            w_upd_valid_nxt = 1'b0;
            w_locked_nxt    = 1'b0;
            w_sel_pd_nxt    = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && cal_enable) begin
                        w_state_nxt    = S_PU_SETTLE;
                        w_locked_nxt   = 1'b0;
                        w_sat_err_nxt  = 1'b0;
                        w_rev_nxt      = '0;
                        w_prev_vld_nxt = 1'b0;
                        w_sel_pd_nxt   = 1'b0;
                        w_set_cnt_nxt  = '0;
                    end
                end
                S_PU_SETTLE, S_PD_SETTLE: begin
                    if (w_tick) begin
                        if (r_set_cnt == c_SET_LAST) begin
                            w_set_cnt_nxt = '0;
                            w_state_nxt   = (r_state == S_PU_SETTLE) ? S_PU_SAMPLE : S_PD_SAMPLE;
                        end else begin
                            w_set_cnt_nxt = r_set_cnt + 1'b1;
                        end
                    end
                end
                S_PU_SAMPLE, S_PD_SAMPLE: begin
                    if (w_eval) begin
                        if (w_rev_upd == c_LOCK) begin
                            w_rev_nxt = w_rev_upd;
                            w_done    = 1'b1;
                        end else if (w_at_lim) begin
                            w_sat_err_nxt = 1'b1;
                            w_done        = 1'b1;
                        end else begin
                            w_rev_nxt      = w_rev_upd;
                            w_prev_dir_nxt = w_dir;
                            w_prev_vld_nxt = 1'b1;
                            if (r_state == S_PU_SAMPLE) begin
                                w_pu_code_nxt = w_stepped;
                                w_state_nxt   = S_PU_SETTLE;
                            end else begin
                                w_pd_code_nxt = w_stepped;
                                w_state_nxt   = S_PD_SETTLE;
                            end
                        end
                        if (w_done && r_state == S_PU_SAMPLE) begin
                            w_state_nxt    = S_PD_SETTLE;
                            w_sel_pd_nxt   = 1'b1;
                            w_rev_nxt      = '0;
                            w_prev_vld_nxt = 1'b0;
                        end else if (w_done) begin
                            w_state_nxt     = S_UPDATE;
                            w_upd_valid_nxt = 1'b1;
                        end
                    end
                end
                S_UPDATE: begin
                    if (upd_ack) begin
                        w_state_nxt     = S_IDLE;
                        w_upd_valid_nxt = 1'b0;
                        w_locked_nxt    = ~r_sat_err;
                        w_sel_pd_nxt    = 1'b0;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge l2clk) begin
        if (global_reset) begin
            r_state     <= S_IDLE;
            r_set_cnt   <= '0;
            r_rev       <= '0;
            r_prev_dir  <= 1'b0;
            r_prev_vld  <= 1'b0;
            r_pu_code   <= c_CODE_MID;
            r_pd_code   <= c_CODE_MID;
            r_sel_pd    <= 1'b0;
            r_upd_valid <= 1'b0;
            r_locked    <= 1'b0;
            r_sat_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_set_cnt   <= w_set_cnt_nxt;
            r_rev       <= w_rev_nxt;
            r_prev_dir  <= w_prev_dir_nxt;
            r_prev_vld  <= w_prev_vld_nxt;
            r_pu_code   <= w_pu_code_nxt;
            r_pd_code   <= w_pd_code_nxt;
            r_sel_pd    <= w_sel_pd_nxt;
            r_upd_valid <= w_upd_valid_nxt;
            r_locked    <= w_locked_nxt;
            r_sat_err   <= w_sat_err_nxt;
        end
    end

    assign pu_code   = r_pu_code;
    assign pd_code   = r_pd_code;
    assign sel_pd    = r_sel_pd;
    assign upd_valid = r_upd_valid;
    assign busy      = (r_state != S_IDLE);
    assign locked    = r_locked;
    assign sat_err   = r_sat_err;

endmodule
`default_nettype wire

// File: tb/tb_bw_io_impctl_cal_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_bw_io_impctl_cal_seq
// Brief    : Randomized bench for the impctl calibration sequencer, compared
//            every cycle against a tick-indexed calibration model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bw_io_impctl_cal_seq;

    localparam int CODE_W       = 8;
    localparam int DIV_LOG2     = 3;
    localparam int SETTLE_TICKS = 4;
    localparam int LOCK_CNT     = 3;
    localparam int TICK_P       = 1 << DIV_LOG2;
    localparam int CODE_TOP     = (1 << CODE_W) - 1;
`ifdef IMPCTL_CAL_AVG_EN
    localparam int NS = 3;
`else
    localparam int NS = 1;
`endif

    logic              l2clk = 1'b0;
    logic              global_reset = 1'b1;
    logic              start = 1'b0;
    logic              cal_enable = 1'b0;
    logic              comp_hi = 1'b0;
    logic              upd_ack = 1'b0;
    logic [CODE_W-1:0] pu_code;
    logic [CODE_W-1:0] pd_code;
    logic              sel_pd;
    logic              upd_valid;
    logic              busy;
    logic              locked;
    logic              sat_err;

    bw_io_impctl_cal_seq #(
        .CODE_W       (CODE_W),
        .DIV_LOG2     (DIV_LOG2),
        .SETTLE_TICKS (SETTLE_TICKS),
        .LOCK_CNT     (LOCK_CNT)
    ) dut (
        .l2clk        (l2clk),
        .global_reset (global_reset),
        .start        (start),
        .cal_enable   (cal_enable),
        .comp_hi      (comp_hi),
        .upd_ack      (upd_ack),
        .pu_code      (pu_code),
        .pd_code      (pd_code),
        .sel_pd       (sel_pd),
        .upd_valid    (upd_valid),
        .busy         (busy),
        .locked       (locked),
        .sat_err      (sat_err)
    );

    always #5 l2clk = ~l2clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_cyc    = 0;

    // Model: phase 0 idle, 1 pull-up, 2 pull-down, 3 awaiting ack.
    int m_ph, m_t, m_nstep, m_rev;
    bit m_prev, m_pvld, m_sat, m_lock;
    int m_code[2];
    bit m_smp[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic enter_phase();
        m_rev = 0; m_pvld = 0; m_t = 0; m_nstep = 0;
        m_smp.delete();
    endtask

    task automatic model_reset();
        m_ph = 0; m_code[0] = 1 << (CODE_W-1); m_code[1] = 1 << (CODE_W-1);
        m_lock = 0; m_sat = 0; m_prev = 0;
        enter_phase();
    endtask

    task automatic model_edge(input bit st, input bit en, input bit comp, input bit ack, input bit tk);
        int ones, idx;
        bit up, done;
        if (m_ph == 0) begin
            if (st && en) begin
                m_ph = 1; m_lock = 0; m_sat = 0;
                enter_phase();
            end
        end else if (!en) begin
            m_ph = 0; m_lock = 0;
        end else if (m_ph == 3) begin
            if (ack) begin m_ph = 0; m_lock = !m_sat; end
        end else if (tk) begin
            m_t++;
            if (m_t > SETTLE_TICKS) m_smp.push_back(comp);
            if (m_t == SETTLE_TICKS + NS) begin
                ones = 0; done = 0; idx = m_ph - 1;
                foreach (m_smp[i]) ones += int'(m_smp[i]);
                up = (2 * ones > NS);
                m_smp.delete(); m_t = 0; m_nstep++;
                if (m_pvld && up != m_prev) m_rev++;
                if (m_rev == LOCK_CNT) done = 1;
                else if ((up && m_code[idx] == CODE_TOP) || (!up && m_code[idx] == 0)) begin
                    m_sat = 1; done = 1;
                end else begin
                    m_code[idx] += up ? 1 : -1;
                    m_prev = up; m_pvld = 1;
                end
                if (done) begin m_ph++; enter_phase(); end
            end
        end
    endtask

    task automatic check_outputs();
        check_eq("pu_code", pu_code, m_code[0]);
        check_eq("pd_code", pd_code, m_code[1]);
        check_eq("flags{busy,sel_pd,upd_valid,locked,sat_err}",
                 {busy, sel_pd, upd_valid, locked, sat_err},
                 {m_ph != 0, m_ph >= 2, m_ph == 3, m_lock, m_sat});
    endtask

    function automatic bit tick_now();
        return (n_cyc % TICK_P) == TICK_P - 1;
    endfunction

    // Called at a falling edge; returns at the next falling edge.
    task automatic step_cycle(input bit st, input bit en, input bit comp, input bit ack);
        bit tk;
        start = st; cal_enable = en; comp_hi = comp; upd_ack = ack;
        tk = tick_now();
        @(posedge l2clk);
        n_cyc++;
        model_edge(st, en, comp, ack, tk);
        #1;
        check_outputs();
        @(negedge l2clk);
    endtask

    task automatic do_reset(input int ncyc);
        global_reset = 1'b1; start = 1'b0; cal_enable = 1'b0; comp_hi = 1'b0; upd_ack = 1'b0;
        repeat (ncyc) @(posedge l2clk);
        model_reset();
        n_cyc = 0;
        #1;
        check_outputs();
        @(negedge l2clk);
        global_reset = 1'b0;
    endtask

    // mode: 0 random, 1 comp=1, 2 comp=0, 3 alternate 1,0 per step (sample ticks only).
    task automatic run_cal(input int mode, input int ack_dly, input int abort_ph, input int rst_ph);
        int budget, upd_cnt;
        bit st, en, ack, cv, tk;
        step_cycle(1'b1, 1'b1, 1'($urandom), 1'b0);
        budget = 40000; upd_cnt = 0;
        while (m_ph != 0 && budget > 0) begin
            tk = tick_now();
            case (mode)
                1:       cv = tk ? 1'b1 : 1'($urandom);
                2:       cv = tk ? 1'b0 : 1'($urandom);
                3:       cv = tk ? (m_nstep % 2 == 0) : 1'($urandom);
                default: cv = 1'($urandom);
            endcase
            st = ($urandom_range(15) == 0);
            en = 1'b1;
            if (m_ph == 3) begin
                ack = (upd_cnt >= ack_dly);
                upd_cnt++;
            end else begin
                ack = 1'($urandom);
            end
            if (m_ph == rst_ph && m_t == 1) begin
                do_reset(2);
                break;
            end
            if (m_ph == abort_ph && ((m_ph == 3) ? (upd_cnt == 3) : (m_t == 1))) en = 1'b0;
            step_cycle(st, en, cv, ack);
            budget--;
        end
        check_eq("cal_returns_idle", busy, 0);
    endtask

    initial begin
        do_reset(2);
        check_eq("rst_pu_mid", pu_code, 8'h80);
        check_eq("rst_pd_mid", pd_code, 8'h80);
        check_eq("rst_flags", {sel_pd, upd_valid, busy, locked, sat_err}, 5'b0);

        // Idle: ack ignored, start without enable ignored.
        step_cycle(1'b0, 1'b1, 1'b1, 1'b1);
        step_cycle(1'b1, 1'b0, 1'b0, 1'b1);
        step_cycle(1'b0, 1'b0, 1'b1, 1'b0);

        // Dithering comparator locks both legs one step above midscale.
        run_cal(3, 5, 0, 0);
        check_eq("lock_pu", pu_code, 8'h81);
        check_eq("lock_pd", pd_code, 8'h81);
        check_eq("lock_flag", locked, 1);

        // Long wait for the pad-side ack.
        run_cal(0, 100, 0, 0);

        // Comparator stuck high: both legs saturate at full scale.
        run_cal(1, 2, 0, 0);
        check_eq("sat_hi_pu", pu_code, 8'hFF);
        check_eq("sat_hi_pd", pd_code, 8'hFF);
        check_eq("sat_hi_flags", {locked, sat_err}, 2'b01);
        run_cal(1, 3, 0, 0);

        // Comparator stuck low: walk down to zero.
        run_cal(2, 1, 0, 0);
        check_eq("sat_lo_pu", pu_code, 8'h00);
        check_eq("sat_lo_pd", pd_code, 8'h00);

        // Abort during pull-down settle.
        run_cal(3, 5, 2, 0);
        check_eq("abort_pu", pu_code, 8'h01);
        check_eq("abort_pd", pd_code, 8'h00);
        check_eq("abort_flags", {upd_valid, locked, sel_pd}, 3'b000);
        run_cal(3, 5, 1, 0);
        run_cal(3, 10, 3, 0);

        // Reset in the middle of the pull-down leg.
        run_cal(3, 5, 0, 2);
        check_eq("midrst_pu", pu_code, 8'h80);
        check_eq("midrst_pd", pd_code, 8'h80);

        for (int i = 0; i < 6; i++) begin
            run_cal(0, $urandom_range(20), ($urandom_range(3) == 0) ? $urandom_range(1, 3) : 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
